// File: rtl/image_writer.sv
// Frame capture into an on-chip pixel memory, with an independent registered read port.
// A frame opens on start, closes after NUMPIXELS accepted pixels, and pulses frame_done once.
module image_writer #(
  parameter int NUMPIXELS  = 1024,
  parameter int PIXELWIDTH = 16,
  parameter int ADDRWIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pixel_valid,
  input  logic [PIXELWIDTH-1:0] pixel_in,
  output logic                  ready,
  output logic                  frame_done,
  output logic                  err_overflow,
  output logic [ADDRWIDTH:0]    pixel_count,
  input  logic                  rd_en,
  input  logic [ADDRWIDTH-1:0]  rd_addr,
  output logic [PIXELWIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  // state   | meaning
  // IDLE    | no frame open; pixel_count holds the last frame's count
  // CAPTURE | frame open, pixel_valid writes to memory at pixel_count
  // DONE    | single cycle after the last pixel, drives frame_done
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [ADDRWIDTH:0] LP_LAST = (ADDRWIDTH+1)'(NUMPIXELS - 1);
  localparam logic [ADDRWIDTH:0] LP_NUM  = (ADDRWIDTH+1)'(NUMPIXELS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDRWIDTH:0]    r_count;
  logic                  r_err;
  logic                  r_rd_valid;
  logic [PIXELWIDTH-1:0] r_rd_data;
  logic [PIXELWIDTH-1:0] r_mem [NUMPIXELS];

  logic w_wr;
  logic w_last;
  logic w_in_range;

  // start always wins over a same-cycle pixel, so the start cycle never writes
  assign w_wr       = (r_state == CAPTURE) && pixel_valid && !start && !rst;
  assign w_last     = (r_count == LP_LAST);
  assign w_in_range = ({1'b0, rd_addr} < LP_NUM);

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        ready = !rst;
        if (!start && w_wr && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        // a start here restarts capture and suppresses this frame's pulse
        frame_done  = !start && !rst;
        w_state_nxt = start ? CAPTURE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_count <= '0;
      end else if (w_wr) begin
        r_count <= r_count + (ADDRWIDTH+1)'(1);
      end
      if (start) begin
        r_err <= 1'b0;
      end else if (pixel_valid && (r_state != CAPTURE)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Memory is intentionally not reset; frame contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[ADDRWIDTH-1:0]] <= pixel_in;
  end

  // Non-blocking read of r_mem returns pre-write data on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_in_range ? r_mem[rd_addr] : '0;
    end
  end

  assign err_overflow = r_err;
  assign pixel_count  = r_count;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;

endmodule

// File: doc/image_writer.md
IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 SHALL have parameter NUMPIXELS, default 1024, meaning pixels per frame (32x32 image).
REQ-002 SHALL have parameter PIXELWIDTH, default 16, meaning bits per pixel.
REQ-003 SHALL have parameter ADDRWIDTH, default 10, meaning frame-memory address width; NUMPIXELS <= 2^ADDRWIDTH.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that opens a new frame capture.
REQ-007 SHALL have port pixel_valid  input  1  pixel_in carries a pixel this cycle.
REQ-008 SHALL have port pixel_in  input  PIXELWIDTH  streamed pixel, raster order.
REQ-009 SHALL have port ready  output  1  high while a frame is being captured.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-011 SHALL have port err_overflow  output  1  sticky flag for a pixel offered while not capturing.
REQ-012 SHALL have port pixel_count  output  ADDRWIDTH+1  pixels written in the current or last frame.
REQ-013 SHALL have port rd_en  input  1  random-access read request.
REQ-014 SHALL have port rd_addr  input  ADDRWIDTH  read address.
REQ-015 SHALL have port rd_data  output  PIXELWIDTH  registered read data.
REQ-016 SHALL have port rd_valid  output  1  rd_data is valid this cycle.

Function
REQ-017 SHALL implement an FSM with states IDLE, CAPTURE, DONE.
REQ-018 IDLE -> CAPTURE SHALL occur on start=1; the pixel on the start cycle SHALL NOT be captured.
REQ-019 In CAPTURE, each cycle with pixel_valid=1 SHALL write pixel_in to memory at address pixel_count, then increment pixel_count by 1.
REQ-020 The write that brings pixel_count to NUMPIXELS SHALL move the FSM to DONE.
REQ-021 DONE SHALL last exactly one cycle, assert frame_done, and return to IDLE; latency from the last accepted pixel to frame_done SHALL be 1 cycle.
REQ-022 ready SHALL be 1 only in CAPTURE.
REQ-023 start in CAPTURE or DONE SHALL abort the frame: pixel_count cleared to 0, state CAPTURE, no frame_done for the aborted frame, and a same-cycle pixel ignored.
REQ-024 pixel_valid=1 in IDLE or DONE without start SHALL set err_overflow and SHALL NOT write memory.
REQ-025 err_overflow SHALL stay set until start or rst clears it; start clears it even if it would otherwise set that same cycle.
REQ-026 pixel_count SHALL hold its final value in IDLE until the next start.
REQ-027 Read port: rd_en=1 at cycle n SHALL give rd_data and rd_valid=1 at cycle n+1; rd_valid=0 otherwise; rd_data holds its last value when rd_en=0.
REQ-028 rd_addr >= NUMPIXELS SHALL return rd_data=0 with rd_valid=1.
REQ-029 A read and write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-030 Reads SHALL be legal in every state and SHALL NOT affect capture.

Reset
REQ-031 rst=1 SHALL force IDLE, ready=0, frame_done=0, err_overflow=0, pixel_count=0, rd_valid=0, rd_data=0, and SHALL take priority over start.
REQ-032 rst mid-CAPTURE SHALL abort the frame without frame_done; memory contents SHALL NOT be reset.

Verification
REQ-033 Full frame: start, then 1024 pixels valued 0..1023 back-to-back -> ready falls, frame_done pulses 1 cycle after pixel 1023, pixel_count=1024; read addr 5 -> rd_data=5 next cycle.
REQ-034 Gapped stream: pixel_valid toggles 1/0 over 2048 cycles -> exactly 1024 writes, frame_done once, pixel_count=1024.
REQ-035 Overflow: pixel_valid=1 in IDLE -> err_overflow=1, memory unchanged; next start -> err_overflow=0.
REQ-036 Restart: start, 300 pixels 0xAAAA, start, 1024 pixels 0x5555 -> single frame_done, addr 0 and 299 read 0x5555.
REQ-037 Reset mid-frame: rst after 500 pixels -> pixel_count=0, ready=0, no frame_done; addr 499 keeps written value.
REQ-038 Read edges: rd_addr=1023 while writing 1023 same cycle -> old data; rd_addr out of range (NUMPIXELS=1000, addr 1010) -> rd_data=0, rd_valid=1.
